// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: walks the PC, glues two-word
// (immediate-carrying) instructions together and honours redirects from decode/execute.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_pc_enable,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        pop_pc1,
  input  logic        pop_pc2,
  input  logic [15:0] stack_rdata,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        if_id_valid,
  output logic [4:0]  if_id_opcode,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_imm,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_next,
  output logic        dbg_state
);

  typedef enum logic {
    S_FETCH     = 1'b0,
    S_FETCH_IMM = 1'b1
  } state_t;

  localparam logic [4:0] OP_LDM   = 5'b10001;
  localparam logic [4:0] OP_IMM_A = 5'b01101;
  localparam logic [4:0] OP_IMM_B = 5'b01110;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hold_word_q, hold_word_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [15:0] popped_hi_q, popped_hi_d;
  logic [15:0] popped_lo_q, popped_lo_d;

  // IF/ID entry: if_id_valid=1 means the fields carry a real instruction;
  // there is no back-pressure other than fetch_pc_enable, which holds the entry.
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] epc_next_q, epc_next_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        word_is_two;
  logic [31:0] pc_plus1;

  assign pc_plus1    = pc_q + 32'd1;
  assign word_is_two = (imem_rdata[15:11] == OP_LDM) ||
                       (imem_rdata[15:11] == OP_IMM_A) ||
                       (imem_rdata[15:11] == OP_IMM_B);
  assign redirect    = branch_taken || (pc_sel != 2'b00);

  // Execute-stage branch wins over any control-unit PC source.
  always_comb begin
    redirect_pc = branch_target;
    if (!branch_taken) begin
      case (pc_sel)
        2'b01:   redirect_pc = branch_target;
        2'b10:   redirect_pc = {popped_hi_q, popped_lo_q};
        2'b11:   redirect_pc = INT_VECTOR;
        default: redirect_pc = pc_plus1;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    epc_d       = epc_q;
    epc_next_d  = epc_next_q;

    if (redirect) begin
      // Any half-fetched two-word instruction is abandoned.
      pc_d       = redirect_pc;
      state_d    = S_FETCH;
      valid_d    = 1'b0;
      instr_d    = 16'h0000;
      imm_d      = 16'h0000;
      epc_d      = 32'h0;
      epc_next_d = 32'h0;
    end else if (fetch_pc_enable) begin
      pc_d = pc_plus1;
      case (state_q)
        S_FETCH: begin
          if (word_is_two) begin
            hold_word_d = imem_rdata;
            hold_pc_d   = pc_q;
            state_d     = S_FETCH_IMM;
            valid_d     = 1'b0;
            instr_d     = 16'h0000;
            imm_d       = 16'h0000;
            epc_d       = 32'h0;
            epc_next_d  = 32'h0;
          end else begin
            valid_d    = 1'b1;
            instr_d    = imem_rdata;
            imm_d      = 16'h0000;
            epc_d      = pc_q;
            epc_next_d = pc_plus1;
          end
        end
        S_FETCH_IMM: begin
          state_d    = S_FETCH;
          valid_d    = 1'b1;
          instr_d    = hold_word_q;
          imm_d      = imem_rdata;
          epc_d      = hold_pc_q;
          epc_next_d = hold_pc_q + 32'd2;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Return-address halves load regardless of freeze or redirect.
  always_comb begin
    popped_hi_d = popped_hi_q;
    popped_lo_d = popped_lo_q;
    if (pop_pc2) popped_hi_d = stack_rdata;
    if (pop_pc1) popped_lo_d = stack_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      hold_word_q <= 16'h0000;
      hold_pc_q   <= 32'h0;
      popped_hi_q <= 16'h0000;
      popped_lo_q <= 16'h0000;
      valid_q     <= 1'b0;
      instr_q     <= 16'h0000;
      imm_q       <= 16'h0000;
      epc_q       <= 32'h0;
      epc_next_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      popped_hi_q <= popped_hi_d;
      popped_lo_q <= popped_lo_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      imm_q       <= imm_d;
      epc_q       <= epc_d;
      epc_next_q  <= epc_next_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_id_valid   = valid_q;
  assign if_id_instr   = instr_q;
  assign if_id_opcode  = instr_q[15:11];
  assign if_id_imm     = imm_q;
  assign if_id_pc      = epc_q;
  assign if_id_pc_next = epc_next_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction ROM answers imem_addr
// combinationally; each scenario task checks hand-computed values inline.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        fetch_pc_enable;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pop_pc1;
  logic        pop_pc2;
  logic [15:0] stack_rdata;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_id_valid;
  logic [4:0]  if_id_opcode;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_next;
  logic        dbg_state;

  logic [15:0] rom [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .fetch_pc_enable(fetch_pc_enable), .pc_sel(pc_sel),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .stack_rdata(stack_rdata),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_opcode(if_id_opcode), .if_id_instr(if_id_instr), .if_id_imm(if_id_imm),
    .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[31:6] == 26'd0) imem_rdata = rom[imem_addr[5:0]];
    else                          imem_rdata = 16'h1800;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] tgt);
    branch_taken = 1'b1; branch_target = tgt;
    tick();
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp %h", imem_addr, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
    n_checks++; if ({if_id_instr, if_id_imm} !== 32'h0) begin n_fail++; $display("FAIL rst_instr_imm got %h exp 0", {if_id_instr, if_id_imm}); end
    n_checks++; if ({if_id_pc, if_id_pc_next} !== 64'h0) begin n_fail++; $display("FAIL rst_pcs got %h exp 0", {if_id_pc, if_id_pc_next}); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state got %b exp 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    tick();
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got %b exp 1", if_id_valid); end
    n_checks++; if (if_id_instr !== 16'h1800) begin n_fail++; $display("FAIL run_instr got %h exp 1800", if_id_instr); end
    n_checks++; if (if_id_opcode !== 5'b00011) begin n_fail++; $display("FAIL run_opcode got %b exp 00011", if_id_opcode); end
    n_checks++; if (if_id_imm !== 16'h0) begin n_fail++; $display("FAIL run_imm got %h exp 0", if_id_imm); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++; if (if_id_pc !== 32'(i)) begin n_fail++; $display("FAIL run_pc got %h exp %h", if_id_pc, 32'(i)); end
      n_checks++; if (if_id_pc_next !== 32'(i + 1)) begin n_fail++; $display("FAIL run_pc_next got %h exp %h", if_id_pc_next, 32'(i + 1)); end
      n_checks++; if (imem_addr !== 32'(i + 1)) begin n_fail++; $display("FAIL run_addr got %h exp %h", imem_addr, 32'(i + 1)); end
    end
  endtask

  task automatic test_ldm();
    jump(32'h4);
    n_checks++; if ({imem_addr, if_id_valid} !== {32'h4, 1'b0}) begin n_fail++; $display("FAIL ldm_jump got %h/%b exp 4/0", imem_addr, if_id_valid); end
    tick();
    n_checks++; if ({imem_addr, dbg_state, if_id_valid} !== {32'h5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ldm_bubble got %h/%b/%b exp 5/1/0", imem_addr, dbg_state, if_id_valid); end
    tick();
    n_checks++; if ({if_id_valid, if_id_instr, if_id_imm} !== {1'b1, 16'h8800, 16'hBEEF}) begin n_fail++; $display("FAIL ldm_entry got %b/%h/%h exp 1/8800/beef", if_id_valid, if_id_instr, if_id_imm); end
    n_checks++; if (if_id_opcode !== 5'b10001) begin n_fail++; $display("FAIL ldm_opcode got %b exp 10001", if_id_opcode); end
    n_checks++; if ({if_id_pc, if_id_pc_next} !== {32'h4, 32'h6}) begin n_fail++; $display("FAIL ldm_pcs got %h/%h exp 4/6", if_id_pc, if_id_pc_next); end
    n_checks++; if ({imem_addr, dbg_state} !== {32'h6, 1'b0}) begin n_fail++; $display("FAIL ldm_next got %h/%b exp 6/0", imem_addr, dbg_state); end
    // 01101 is also two-word: 0x6800 at 8, 0x1234 at 9
    jump(32'h8);
    tick();
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL op0d_bubble got %b exp 0", if_id_valid); end
    tick();
    n_checks++; if ({if_id_instr, if_id_imm, if_id_pc_next} !== {16'h6800, 16'h1234, 32'hA}) begin n_fail++; $display("FAIL op0d_entry got %h/%h/%h exp 6800/1234/a", if_id_instr, if_id_imm, if_id_pc_next); end
  endtask

  task automatic test_freeze();
    // hold a valid one-word entry
    jump(32'h20);
    tick();
    fetch_pc_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({imem_addr, if_id_valid, if_id_pc} !== {32'h21, 1'b1, 32'h20}) begin n_fail++; $display("FAIL frz1_hold got %h/%b/%h exp 21/1/20", imem_addr, if_id_valid, if_id_pc); end
    end
    fetch_pc_enable = 1'b1;
    jump(32'h4);
    tick();
    fetch_pc_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({imem_addr, dbg_state, if_id_valid} !== {32'h5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL frz_hold got %h/%b/%b exp 5/1/0", imem_addr, dbg_state, if_id_valid); end
    end
    fetch_pc_enable = 1'b1;
    tick();
    n_checks++; if ({if_id_valid, if_id_instr, if_id_imm} !== {1'b1, 16'h8800, 16'hBEEF}) begin n_fail++; $display("FAIL frz_release got %b/%h/%h exp 1/8800/beef", if_id_valid, if_id_instr, if_id_imm); end
    n_checks++; if ({if_id_pc_next, imem_addr} !== {32'h6, 32'h6}) begin n_fail++; $display("FAIL frz_release_pc got %h/%h exp 6/6", if_id_pc_next, imem_addr); end
  endtask

  task automatic test_branch_mid_imm();
    jump(32'h4);
    tick();
    // redirect while frozen still wins
    fetch_pc_enable = 1'b0;
    jump(32'h40);
    fetch_pc_enable = 1'b1;
    n_checks++; if ({imem_addr, dbg_state, if_id_valid} !== {32'h40, 1'b0, 1'b0}) begin n_fail++; $display("FAIL br_redirect got %h/%b/%b exp 40/0/0", imem_addr, dbg_state, if_id_valid); end
    tick();
    n_checks++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_next} !== {1'b1, 16'h1800, 32'h40, 32'h41}) begin n_fail++; $display("FAIL br_after got %b/%h/%h/%h exp 1/1800/40/41", if_id_valid, if_id_instr, if_id_pc, if_id_pc_next); end
  endtask

  task automatic test_pc_sel();
    pop_pc2 = 1'b1; stack_rdata = 16'h0001;
    tick();
    pop_pc2 = 1'b0; pop_pc1 = 1'b1; stack_rdata = 16'h2345;
    tick();
    pop_pc1 = 1'b0; pc_sel = 2'b10;
    tick();
    pc_sel = 2'b00;
    n_checks++; if ({imem_addr, if_id_valid} !== {32'h0001_2345, 1'b0}) begin n_fail++; $display("FAIL pop_pc got %h/%b exp 00012345/0", imem_addr, if_id_valid); end
    tick();
    pop_pc1 = 1'b1; pop_pc2 = 1'b1; stack_rdata = 16'hAAAA; pc_sel = 2'b10;
    tick();
    pop_pc1 = 1'b0; pop_pc2 = 1'b0;
    n_checks++; if (imem_addr !== 32'h0001_2345) begin n_fail++; $display("FAIL pop_same_edge got %h exp 00012345", imem_addr); end
    tick();
    n_checks++; if (imem_addr !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL pop_both got %h exp aaaaaaaa", imem_addr); end
    pc_sel = 2'b11;
    tick();
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL int_vec got %h exp 10", imem_addr); end
    pc_sel = 2'b01; branch_target = 32'h33;
    tick();
    n_checks++; if (imem_addr !== 32'h33) begin n_fail++; $display("FAIL sel_target got %h exp 33", imem_addr); end
    pc_sel = 2'b11; branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    pc_sel = 2'b00; branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_priority got %h exp 20", imem_addr); end
  endtask

  task automatic test_wrap();
    jump(32'hFFFF_FFFF);
    tick();
    n_checks++; if ({if_id_valid, if_id_pc, if_id_pc_next} !== {1'b1, 32'hFFFF_FFFF, 32'h0}) begin n_fail++; $display("FAIL wrap_entry got %b/%h/%h exp 1/ffffffff/0", if_id_valid, if_id_pc, if_id_pc_next); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({imem_addr, if_id_valid, if_id_pc_next} !== {32'h0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL arst_valid got %h/%b/%h exp 0/0/0", imem_addr, if_id_valid, if_id_pc_next); end
    @(negedge clk); rst = 1'b0;
    jump(32'h4);
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({imem_addr, dbg_state, if_id_valid} !== {32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL arst_imm got %h/%b/%b exp 0/0/0", imem_addr, dbg_state, if_id_valid); end
    @(negedge clk); rst = 1'b0;
    tick();
    n_checks++; if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'h0, 32'h1}) begin n_fail++; $display("FAIL arst_restart got %b/%h/%h exp 1/0/1", if_id_valid, if_id_pc, imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h1800;
    rom[4] = 16'h8800; rom[5] = 16'hBEEF;
    rom[8] = 16'h6800; rom[9] = 16'h1234;
    fetch_pc_enable = 1'b1; pc_sel = 2'b00; branch_taken = 1'b0; branch_target = 32'h0;
    pop_pc1 = 1'b0; pop_pc2 = 1'b0; stack_rdata = 16'h0; rst = 1'b0;
    test_reset();
    test_free_run();
    test_ldm();
    test_freeze();
    test_branch_mid_imm();
    test_pc_sel();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
